// File: rtl/freq_meter_ctrl.sv
// Measurement sequencer for the dual-counter frequency meter: settle/gate window,
// count handshake, iterative divide. Define FREQ_ROUND_EN for round-to-nearest results.
module freq_meter_ctrl #(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned SETTLE_CYCLES  = 12_500_000,
    parameter int unsigned GATE_CYCLES    = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 25_000_000,
    parameter int unsigned STAND_CLK_FREQ = 100_000_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             continuous,
    input  logic [CNT_W-1:0] cnt_test_in,
    input  logic [CNT_W-1:0] cnt_stand_in,
    input  logic             cnt_vld,
    output logic             gate_out,
    output logic             busy,
    output logic [31:0]      freq,
    output logic             freq_vld,
    output logic             err_timeout,
    output logic             err_zero
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_GATE   = 3'd2;
    localparam logic [2:0] S_POST   = 3'd3;
    localparam logic [2:0] S_MUL    = 3'd4;
    localparam logic [2:0] S_DIV    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [31:0] SETTLE_LD  = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] GATE_LD    = 32'(GATE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LD = 32'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [31:0]      tmr_q, tmr_d;
    logic             gate_q, gate_d;
    logic [31:0]      freq_q, freq_d;
    logic             freq_vld_q, freq_vld_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_zero_q, err_zero_d;
    logic [CNT_W-1:0] test_q, test_d;
    logic [CNT_W-1:0] stand_q, stand_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [63:0]      quo_q, quo_d;

    logic [63:0]      num;
    logic [CNT_W:0]   trial;
    logic [CNT_W:0]   diff;
    logic             ge;

    always_comb begin
        num = 64'(STAND_CLK_FREQ) * {{(64-CNT_W){1'b0}}, test_q};
`ifdef FREQ_ROUND_EN
        num = num + {{(64-CNT_W){1'b0}}, stand_q >> 1};
`endif
        // quo_q doubles as the numerator shift register during the divide
        trial = {rem_q, quo_q[63]};
        diff  = trial - {1'b0, stand_q};
        ge    = (trial >= {1'b0, stand_q});
    end

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        gate_d        = gate_q;
        freq_d        = freq_q;
        freq_vld_d    = 1'b0;
        err_timeout_d = err_timeout_q;
        err_zero_d    = err_zero_q;
        test_d        = test_q;
        stand_d       = stand_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        if (abort) begin
            state_d = S_IDLE;
            gate_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_d       = S_SETTLE;
                    tmr_d         = SETTLE_LD;
                    err_timeout_d = 1'b0;
                    err_zero_d    = 1'b0;
                end
                S_SETTLE: if (tmr_q == '0) begin
                    state_d = S_GATE;
                    gate_d  = 1'b1;
                    tmr_d   = GATE_LD;
                end else tmr_d = tmr_q - 32'd1;
                S_GATE: if (tmr_q == '0) begin
                    state_d = S_POST;
                    gate_d  = 1'b0;
                    tmr_d   = TIMEOUT_LD;
                end else tmr_d = tmr_q - 32'd1;
                S_POST: if (cnt_vld) begin
                    state_d = S_MUL;
                    test_d  = cnt_test_in;
                    stand_d = cnt_stand_in;
                end else if (tmr_q == '0) begin
                    state_d       = S_IDLE;
                    err_timeout_d = 1'b1;
                end else tmr_d = tmr_q - 32'd1;
                S_MUL: begin
                    rem_d = '0;
                    tmr_d = 32'd63;
                    if (stand_q == '0) begin
                        state_d    = S_DONE;
                        err_zero_d = 1'b1;
                        quo_d      = '0;
                    end else begin
                        state_d = S_DIV;
                        quo_d   = num;
                    end
                end
                S_DIV: begin
                    quo_d = {quo_q[62:0], ge};
                    rem_d = ge ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
                    if (tmr_q == '0) state_d = S_DONE;
                    else tmr_d = tmr_q - 32'd1;
                end
                S_DONE: begin
                    freq_d     = (|quo_q[63:32]) ? 32'hFFFF_FFFF : quo_q[31:0];
                    freq_vld_d = 1'b1;
                    if (continuous) begin
                        state_d = S_SETTLE;
                        tmr_d   = SETTLE_LD;
                    end else state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= S_IDLE;
            tmr_q         <= '0;
            gate_q        <= 1'b0;
            freq_q        <= '0;
            freq_vld_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            err_zero_q    <= 1'b0;
            test_q        <= '0;
            stand_q       <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            gate_q        <= gate_d;
            freq_q        <= freq_d;
            freq_vld_q    <= freq_vld_d;
            err_timeout_q <= err_timeout_d;
            err_zero_q    <= err_zero_d;
            test_q        <= test_d;
            stand_q       <= stand_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
        end
    end

    assign gate_out    = gate_q;
    assign busy        = (state_q != S_IDLE);
    assign freq        = freq_q;
    assign freq_vld    = freq_vld_q;
    assign err_timeout = err_timeout_q;
    assign err_zero    = err_zero_q;

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Bench for freq_meter_ctrl: vector table, randomized runs against an arithmetic
// model, and hand-written timeout / continuous / abort / reset sequences.
module tb_freq_meter_ctrl;

    localparam int S = 10;
    localparam int G = 100;
    localparam int T = 50;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        continuous = 1'b0;
    logic [31:0] cnt_test_in = '0;
    logic [31:0] cnt_stand_in = '0;
    logic        cnt_vld = 1'b0;
    logic        gate_out, busy, freq_vld, err_timeout, err_zero;
    logic [31:0] freq;

    int checks = 0;
    int errors = 0;

    freq_meter_ctrl #(
        .CNT_W(32), .SETTLE_CYCLES(S), .GATE_CYCLES(G),
        .TIMEOUT_CYCLES(T), .STAND_CLK_FREQ(100_000_000)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .abort(abort),
        .continuous(continuous), .cnt_test_in(cnt_test_in), .cnt_stand_in(cnt_stand_in),
        .cnt_vld(cnt_vld), .gate_out(gate_out), .busy(busy), .freq(freq),
        .freq_vld(freq_vld), .err_timeout(err_timeout), .err_zero(err_zero)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] t;
        logic [31:0] s;
        int          dly;
        logic [31:0] exp_freq;
        logic        exp_zero;
    } vec_t;

    // Reference: freq = round_or_trunc(1e8 * t / s), saturated to 32 bits, 0 on s==0.
    function automatic logic [31:0] ref_freq(input logic [31:0] t, input logic [31:0] s);
        longint unsigned num, q;
        if (s == 0) return 32'd0;
        num = 64'd100_000_000 * longint'(t);
`ifdef FREQ_ROUND_EN
        num = num + longint'(s / 2);
`endif
        q = num / longint'(s);
        return (q > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    // counts edges until gate_out reaches lvl
    task automatic wait_gate(input logic lvl, output int n);
        n = 0;
        while (gate_out !== lvl && n < 1000) begin
            tick;
            n++;
        end
    endtask

    task automatic run_meas(input vec_t v, input logic cont, input string tag);
        int n;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk({tag, " busy_after_start"}, busy, 1);
        chk({tag, " err_timeout_cleared"}, err_timeout, 0);
        chk({tag, " err_zero_cleared"}, err_zero, 0);
        wait_gate(1'b1, n);
        chk({tag, " settle_len"}, n, S);
        wait_gate(1'b0, n);
        chk({tag, " gate_len"}, n, G);
        repeat (v.dly) tick;
        cnt_test_in  = v.t;
        cnt_stand_in = v.s;
        cnt_vld      = 1'b1;
        tick;
        cnt_vld      = 1'b0;
        cnt_test_in  = $urandom;
        cnt_stand_in = $urandom;
        n = 0;
        while (freq_vld !== 1'b1 && n < 200) begin
            tick;
            n++;
        end
        chk({tag, " latency"}, n, (v.s == 0) ? 2 : 66);
        chk({tag, " freq"}, freq, v.exp_freq);
        chk({tag, " err_zero"}, err_zero, v.exp_zero);
        chk({tag, " busy_at_done"}, busy, cont);
        tick;
        chk({tag, " freq_vld_one_cycle"}, freq_vld, 0);
    endtask

    vec_t vecs[6];
    vec_t rv;

    initial begin
        int n;
        logic saw_vld;
        logic [31:0] prev;

        vecs[0] = '{32'd50, 32'd100, 0, 32'd50_000_000, 1'b0};
`ifdef FREQ_ROUND_EN
        vecs[1] = '{32'd2, 32'd3, 5, 32'd66_666_667, 1'b0};
        vecs[4] = '{32'd3, 32'd7, 10, 32'd42_857_143, 1'b0};
`else
        vecs[1] = '{32'd2, 32'd3, 5, 32'd66_666_666, 1'b0};
        vecs[4] = '{32'd3, 32'd7, 10, 32'd42_857_142, 1'b0};
`endif
        vecs[2] = '{32'hFFFF_FFFF, 32'd1, T - 1, 32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{32'd7, 32'd0, 3, 32'd0, 1'b1};
        vecs[5] = '{32'd0, 32'd5, 1, 32'd0, 1'b0};

        // reset state
        repeat (2) tick;
        chk("rst gate_out", gate_out, 0);
        chk("rst busy", busy, 0);
        chk("rst freq", freq, 0);
        chk("rst freq_vld", freq_vld, 0);
        chk("rst err_timeout", err_timeout, 0);
        chk("rst err_zero", err_zero, 0);
        sys_rst_n = 1'b1;
        tick;

        foreach (vecs[i]) run_meas(vecs[i], 1'b0, $sformatf("vec%0d", i));

        for (int i = 0; i < 8; i++) begin
            rv.t = $urandom;
            rv.s = (i % 2 == 0) ? $urandom : $urandom_range(1, 1000);
            if (i == 3) rv.t = $urandom_range(0, 100_000);
            rv.dly = $urandom_range(0, T - 1);
            rv.exp_freq = ref_freq(rv.t, rv.s);
            rv.exp_zero = (rv.s == 0);
            run_meas(rv, 1'b0, $sformatf("rand%0d", i));
        end

        // timeout; stray cnt_vld pulses outside POST must be ignored
        prev = freq;
        start = 1'b1;
        tick;
        start = 1'b0;
        cnt_test_in = 32'd1; cnt_stand_in = 32'd1; cnt_vld = 1'b1;
        tick;
        cnt_vld = 1'b0;
        wait_gate(1'b1, n);
        cnt_vld = 1'b1;
        tick;
        cnt_vld = 1'b0;
        wait_gate(1'b0, n);
        n = 0;
        saw_vld = 1'b0;
        while (busy === 1'b1 && n < 200) begin
            tick;
            n++;
            if (freq_vld) saw_vld = 1'b1;
        end
        chk("timeout cycles", n, T);
        chk("timeout err_timeout", err_timeout, 1);
        chk("timeout no_freq_vld", saw_vld, 0);
        chk("timeout freq_held", freq, prev);
        run_meas(vecs[0], 1'b0, "after_timeout");

        // abort wins over start in IDLE
        start = 1'b1; abort = 1'b1;
        tick;
        start = 1'b0; abort = 1'b0;
        chk("abort_vs_start busy", busy, 0);

        // continuous re-arm, ignored start, abort during second gate
        continuous = 1'b1;
        run_meas(vecs[0], 1'b1, "cont");
        wait_gate(1'b1, n);
        chk("cont second_settle_len", n, S - 1);
        repeat (5) tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("busy_start gate_still_high", gate_out, 1);
        chk("busy_start busy", busy, 1);
        repeat (3) tick;
        continuous = 1'b0;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort gate_out", gate_out, 0);
        chk("abort busy", busy, 0);
        chk("abort freq_held", freq, 32'd50_000_000);
        chk("abort freq_vld", freq_vld, 0);

        // async reset in the middle of a divide
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_gate(1'b1, n);
        wait_gate(1'b0, n);
        cnt_test_in = 32'd123; cnt_stand_in = 32'd45; cnt_vld = 1'b1;
        tick;
        cnt_vld = 1'b0;
        repeat (20) tick;
        #2 sys_rst_n = 1'b0;
        #1;
        chk("mid_div_rst busy", busy, 0);
        chk("mid_div_rst freq", freq, 0);
        chk("mid_div_rst gate_out", gate_out, 0);
        chk("mid_div_rst freq_vld", freq_vld, 0);
        tick;
        sys_rst_n = 1'b1;
        tick;
        run_meas(vecs[1], 1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
